// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = X - Y - B0, one bit per clock, LSB first, single borrow flop.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output V.
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             B0,
    output logic [WIDTH-1:0] diff,
    output logic             B8,
    output logic             busy,
`ifdef SUB_OVERFLOW_EN
    output logic             done,
    output logic             V
`else
    output logic             done
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic             b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b8_q, b8_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SUB_OVERFLOW_EN
    logic             v_q, v_d;
`endif

    logic             bit_d;
    logic             borrow_nxt;

    always_comb begin
        state_d    = state_q;
        xs_d       = xs_q;
        ys_d       = ys_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        diff_d     = diff_q;
        b8_d       = b8_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef SUB_OVERFLOW_EN
        v_d        = v_q;
`endif
        bit_d      = xs_q[0] ^ ys_q[0] ^ b_q;
        borrow_nxt = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & b_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    xs_d    = X;
                    ys_d    = Y;
                    b_d     = B0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                diff_d = {bit_d, diff_q[WIDTH-1:1]};
                xs_d   = xs_q >> 1;
                ys_d   = ys_q >> 1;
                b_d    = borrow_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    b8_d    = borrow_nxt;
`ifdef SUB_OVERFLOW_EN
                    // On the last bit xs/ys LSBs hold the original operand MSBs.
                    v_d     = (xs_q[0] ^ ys_q[0]) & (bit_d ^ xs_q[0]);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            b_q     <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            b8_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            b8_q    <= b8_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SUB_OVERFLOW_EN
            v_q     <= v_d;
`endif
        end
    end

    assign diff = diff_q;
    assign B8   = b8_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SUB_OVERFLOW_EN
    assign V    = v_q;
`endif

endmodule
